// File: rtl/player_control_fsm.sv
// Player control: transport FSM, track index and volume for the audio player.
// Consumes single-cycle button pulses and handshakes track loads with the ROM reader.
module player_control_fsm #(
    parameter int NUM_TRACKS  = 8,
    parameter int TRACK_W     = 3,
    parameter int VOL_W       = 4,
    parameter int VOL_MAX     = 15,
    parameter int VOL_DEFAULT = 8,
    parameter bit LOOP_ALL    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play_pause,
    input  logic               volume_up,
    input  logic               volume_down,
    input  logic               forward,
    input  logic               backward,
    input  logic               load_ack,
    input  logic               track_end,
    output logic [1:0]         state,
    output logic [TRACK_W-1:0] track_idx,
    output logic [VOL_W-1:0]   volume,
    output logic               load_req,
    output logic               audio_en,
    output logic               track_changed
);

    // state | meaning
    // IDLE  | stopped, waiting for play_pause
    // LOAD  | load_req held high until the ROM reader acks track_idx
    // PLAY  | audio running on track_idx
    // PAUSE | track loaded, audio held off
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        PLAY  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    localparam logic [TRACK_W-1:0] LAST_IDX = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [VOL_W-1:0]   VOL_TOP  = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0]   VOL_RST  = VOL_W'(VOL_DEFAULT);

    state_t             cur_state;
    logic               play_after;
    logic [TRACK_W-1:0] idx_inc;
    logic [TRACK_W-1:0] idx_dec;

    assign state   = cur_state;
    assign idx_inc = (track_idx == LAST_IDX) ? '0 : track_idx + 1'b1;
    assign idx_dec = (track_idx == '0) ? LAST_IDX : track_idx - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state     <= IDLE;
            track_idx     <= '0;
            play_after    <= 1'b0;
            load_req      <= 1'b0;
            audio_en      <= 1'b0;
            track_changed <= 1'b0;
        end else begin
            track_changed <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (play_pause) begin
                        play_after <= 1'b1;
                        cur_state  <= LOAD;
                        load_req   <= 1'b1;
                    end
                end
                LOAD: begin
                    // a play_pause coinciding with the ack is dropped
                    if (load_ack) begin
                        load_req <= 1'b0;
                        if (play_after) begin
                            cur_state <= PLAY;
                            audio_en  <= 1'b1;
                        end else begin
                            cur_state <= PAUSE;
                        end
                    end else if (play_pause) begin
                        play_after <= ~play_after;
                    end
                end
                PLAY: begin
                    if (forward) begin
                        track_idx     <= idx_inc;
                        track_changed <= (idx_inc != track_idx);
                        play_after    <= 1'b1;
                        cur_state     <= LOAD;
                        load_req      <= 1'b1;
                        audio_en      <= 1'b0;
                    end else if (backward) begin
                        track_idx     <= idx_dec;
                        track_changed <= (idx_dec != track_idx);
                        play_after    <= 1'b1;
                        cur_state     <= LOAD;
                        load_req      <= 1'b1;
                        audio_en      <= 1'b0;
                    end else if (track_end) begin
                        // idx_inc already wraps the last track to 0
                        track_idx     <= idx_inc;
                        track_changed <= (idx_inc != track_idx);
                        audio_en      <= 1'b0;
                        if (track_idx != LAST_IDX || LOOP_ALL) begin
                            play_after <= 1'b1;
                            cur_state  <= LOAD;
                            load_req   <= 1'b1;
                        end else begin
                            cur_state  <= IDLE;
                        end
                    end else if (play_pause) begin
                        cur_state <= PAUSE;
                        audio_en  <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (forward || backward) begin
                        track_idx     <= forward ? idx_inc : idx_dec;
                        track_changed <= forward ? (idx_inc != track_idx)
                                                 : (idx_dec != track_idx);
                        play_after    <= 1'b0;
                        cur_state     <= LOAD;
                        load_req      <= 1'b1;
                    end else if (play_pause) begin
                        cur_state <= PLAY;
                        audio_en  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            volume <= VOL_RST;
        end else if (volume_up && !volume_down && volume != VOL_TOP) begin
            volume <= volume + 1'b1;
        end else if (volume_down && !volume_up && volume != '0) begin
            volume <= volume - 1'b1;
        end
    end

endmodule
